// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, sequencer state type and command record for the calc sequencer
package calc_pkg;

    localparam int OPW = 2;
    localparam int DW  = 4;
    localparam int RAW = 5;
    localparam int RBW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } calc_cmd_t;

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// rtl/calc_cmd_sequencer_if.sv - command, calculator and result signal bundle of the calc sequencer
//
// Ports (slave = sequencer side, master = producer/calculator/consumer side):
//   cmd_*   command handshake into the FIFO
//   calc_*  operand/opcode/start towards the calculator, results back
//   res_*   captured-result handshake to the consumer
//   cmd_count  issued-command counter
interface calc_cmd_sequencer_if;
    import calc_pkg::*;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [DW-1:0]  cmd_a;
    logic [DW-1:0]  cmd_b;

    logic           calc_start;
    logic [OPW-1:0] calc_ir;
    logic [DW-1:0]  calc_a;
    logic [DW-1:0]  calc_b;
    logic [RAW-1:0] calc_ra;
    logic [RBW-1:0] calc_rb;

    logic           res_valid;
    logic           res_ready;
    logic [OPW-1:0] res_op;
    logic [RAW-1:0] res_a;
    logic [RBW-1:0] res_b;

    logic [7:0]     cmd_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, calc_ra, calc_rb, res_ready,
        output cmd_ready, calc_start, calc_ir, calc_a, calc_b,
               res_valid, res_op, res_a, res_b, cmd_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, calc_ra, calc_rb, res_ready,
        input  cmd_ready, calc_start, calc_ir, calc_a, calc_b,
               res_valid, res_op, res_a, res_b, cmd_count
    );

endinterface

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous command FIFO of DEPTH entries
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write one command (caller guarantees !full)
//   pop, pop_data       pop_data is the head; pop advances it (caller guarantees non-empty)
//   full, count         registered occupancy and its full flag
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  calc_cmd_t                push_data,
    input  logic                     pop,
    output calc_cmd_t                pop_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    calc_cmd_t     mem_q [DEPTH];
    calc_cmd_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Pointers are exactly PW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - queues calculator commands, issues start pulses, captures and presents results
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        calc_cmd_sequencer_if.slave: cmd_* in, calc_* to/from calculator, res_* out, cmd_count
// Build option: CALC_SEQ_CMDCOUNT_EN enables the 8-bit issued-command counter; otherwise cmd_count is 0.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CALC_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_cmd_sequencer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(CALC_LAT + 1);

    seq_state_e     state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [OPW-1:0] calc_ir_q, calc_ir_d;
    logic [DW-1:0]  calc_a_q, calc_a_d;
    logic [DW-1:0]  calc_b_q, calc_b_d;
    logic           res_valid_q, res_valid_d;
    logic [OPW-1:0] res_op_q, res_op_d;
    logic [RAW-1:0] res_a_q, res_a_d;
    logic [RBW-1:0] res_b_q, res_b_d;

    logic           push, pop, full;
    logic [CW-1:0]  count;
    calc_cmd_t      push_data, head;

    assign push_data     = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    assign push          = bus.cmd_valid && !full;
    assign bus.cmd_ready = !full;

    calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .count     (count)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        calc_ir_d   = calc_ir_q;
        calc_a_d    = calc_a_q;
        calc_b_d    = calc_b_q;
        res_valid_d = res_valid_q;
        res_op_d    = res_op_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    calc_ir_d = head.op;
                    calc_a_d  = head.a;
                    calc_b_d  = head.b;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = WW'(CALC_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q - 1'b1;
                // The count of 1 marks the cycle in which the calculator output has settled.
                if (wait_q == WW'(1)) begin
                    res_op_d    = calc_ir_q;
                    res_a_d     = bus.calc_ra;
                    res_b_d     = bus.calc_rb;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            calc_ir_q   <= '0;
            calc_a_q    <= '0;
            calc_b_q    <= '0;
            res_valid_q <= 1'b0;
            res_op_q    <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            calc_ir_q   <= calc_ir_d;
            calc_a_q    <= calc_a_d;
            calc_b_q    <= calc_b_d;
            res_valid_q <= res_valid_d;
            res_op_q    <= res_op_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
        end
    end

    assign bus.calc_start = (state_q == ISSUE);
    assign bus.calc_ir    = calc_ir_q;
    assign bus.calc_a     = calc_a_q;
    assign bus.calc_b     = calc_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_op     = res_op_q;
    assign bus.res_a      = res_a_q;
    assign bus.res_b      = res_b_q;

`ifdef CALC_SEQ_CMDCOUNT_EN
    logic [7:0] cmd_count_q, cmd_count_d;

    always_comb begin
        cmd_count_d = cmd_count_q;
        if (state_q == ISSUE) begin
            cmd_count_d = cmd_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count_q <= 8'd0;
        end else begin
            cmd_count_q <= cmd_count_d;
        end
    end

    assign bus.cmd_count = cmd_count_q;
`else
    assign bus.cmd_count = 8'd0;
`endif

endmodule
